// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU operation codes,
// R-type function codes and the multiply/divide FSM state type.
// Used by the decode stage, the ID/EX register and the execute stage.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MD_STEPS = 32;

  // alu_op encodings driven by the decoder; 6 and 7 behave as ADD
  localparam logic [2:0] AluOpAdd   = 3'd0;
  localparam logic [2:0] AluOpSub   = 3'd1;
  localparam logic [2:0] AluOpAnd   = 3'd2;
  localparam logic [2:0] AluOpOr    = 3'd3;
  localparam logic [2:0] AluOpSlt   = 3'd4;
  localparam logic [2:0] AluOpRtype = 3'd5;

  // R-type funct field values
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  // md op is funct[1:0] of 0x18..0x1B: bit1 = divide, bit0 = unsigned
  typedef enum logic [1:0] {
    MdOpMult  = 2'd0,
    MdOpMultu = 2'd1,
    MdOpDiv   = 2'd2,
    MdOpDivu  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdBusy = 2'd1,
    MdDone = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // funct 0x18..0x1B share the pattern 0110xx
  function automatic logic funct_is_md(input logic [5:0] funct);
    return funct[5:2] == FnMult[5:2];
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI and LO.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// 32 steps, signs fixed up in the DONE state which also writes HI/LO.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      md instruction present (only accepted in IDLE)
//   op         0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   a, b       rs / rt operands
//   busy       upstream must stall (arrival cycle and all BUSY cycles)
//   hi, lo     architectural HI/LO
module md_unit import mips_pkg::*; #(
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic [1:0]  op_q;
  logic        sign_a_q, sign_b_q, div_zero_q;
  logic [31:0] a_raw_q;
  logic [31:0] hi_q, lo_q;

  logic        fast_path;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] fast_prod;
  logic [32:0] add_sum, rem_sh, sub_diff;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] quo, rem, res_hi, res_lo;
  logic        unused_md;

  assign fast_path = FAST_MUL && !md_is_div(op);
  assign a_neg     = md_is_signed(op) & a[31];
  assign b_neg     = md_is_signed(op) & b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;

  // Low 64 bits of the product of extended operands is the exact signed/unsigned product
  assign fast_prod = md_is_signed(op) ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                                      : ({32'd0, a} * {32'd0, b});

  // Stall in the arrival cycle and throughout BUSY; never while reset is asserted
  assign busy = !rst && (((state_q == MdIdle) && start && !fast_path) || (state_q == MdBusy));

  assign hi = hi_q;
  assign lo = lo_q;

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
    rem_sh   = acc_q[63:31];
    sub_diff = rem_sh - {1'b0, mcand_q};
    if (md_is_div(op_q)) begin
      if (rem_sh >= {1'b0, mcand_q}) begin
        acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_step = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    end
  end

  // A successful subtract always leaves a remainder below the divisor
  assign unused_md = sub_diff[32];

  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
    quo  = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (!md_is_div(op_q)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (div_zero_q) begin
      res_hi = a_raw_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MdIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        MdIdle: begin
          if (start) begin
            if (fast_path) begin
              hi_q <= fast_prod[63:32];
              lo_q <= fast_prod[31:0];
            end else begin
              state_q    <= MdBusy;
              cnt_q      <= '0;
              acc_q      <= {32'd0, a_mag};
              mcand_q    <= b_mag;
              op_q       <= op;
              sign_a_q   <= a_neg;
              sign_b_q   <= b_neg;
              div_zero_q <= (b == 32'd0);
              a_raw_q    <= a;
            end
          end
        end
        MdBusy: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(MD_STEPS - 1)) begin
            state_q <= MdDone;
          end
        end
        MdDone: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          state_q <= MdIdle;
        end
        default: state_q <= MdIdle;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// ALU, HI/LO read mux, destination select and the EX/MEM register; the
// md_unit handles MULT/MULTU/DIV/DIVU and drives the upstream stall.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rs_data, rt_data, imm, instr    ID/EX operands and instruction word
//   reg_write, mem_to_reg, mem_write, alu_op, alu_src, reg_dst   ID/EX controls
//   ex_stall                        combinational hold request for earlier stages
//   *_mem                           registered EX/MEM outputs
module ex_stage import mips_pkg::*; #(
  parameter bit FAST_MUL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [XLEN-1:0]   rt_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   instr,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic [2:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  output logic              ex_stall,
  output logic [XLEN-1:0]   alu_res_mem,
  output logic [XLEN-1:0]   st_data_mem,
  output logic [REG_AW-1:0] dest_mem,
  output logic              reg_write_mem,
  output logic              mem_to_reg_mem,
  output logic              mem_write_mem
);

  logic [5:0]        funct;
  logic [REG_AW-1:0] rt_f, rd_f, dest;
  logic              is_md;
  logic [XLEN-1:0]   op_b, add_res, sub_res, slt_res, alu_res;
  logic [XLEN-1:0]   md_hi, md_lo;
  logic              unused_instr;

  assign funct        = instr[5:0];
  assign rt_f         = instr[20:16];
  assign rd_f         = instr[15:11];
  assign unused_instr = ^{instr[31:21], instr[10:6]};

  assign is_md = (alu_op == AluOpRtype) && funct_is_md(funct);
  assign dest  = reg_dst ? rd_f : rt_f;

  md_unit #(
    .FAST_MUL (FAST_MUL)
  ) u_md_unit (
    .clk   (clk),
    .rst   (rst),
    .start (is_md),
    .op    (funct[1:0]),
    .a     (rs_data),
    .b     (rt_data),
    .busy  (ex_stall),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  assign op_b    = alu_src ? imm : rt_data;
  assign add_res = rs_data + op_b;
  assign sub_res = rs_data - op_b;
  assign slt_res = {31'd0, ($signed(rs_data) < $signed(op_b))};

  always_comb begin
    alu_res = add_res;
    case (alu_op)
      AluOpSub: alu_res = sub_res;
      AluOpAnd: alu_res = rs_data & op_b;
      AluOpOr:  alu_res = rs_data | op_b;
      AluOpSlt: alu_res = slt_res;
      AluOpRtype: begin
        case (funct)
          FnSub:  alu_res = sub_res;
          FnAnd:  alu_res = rs_data & op_b;
          FnOr:   alu_res = rs_data | op_b;
          FnSlt:  alu_res = slt_res;
          FnMfhi: alu_res = md_hi;
          FnMflo: alu_res = md_lo;
          FnMult, FnMultu, FnDiv, FnDivu: alu_res = '0;
          default: alu_res = add_res;
        endcase
      end
      default: alu_res = add_res;
    endcase
  end

  // EX/MEM register: a stall inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || ex_stall) begin
      alu_res_mem    <= '0;
      st_data_mem    <= '0;
      dest_mem       <= '0;
      reg_write_mem  <= 1'b0;
      mem_to_reg_mem <= 1'b0;
      mem_write_mem  <= 1'b0;
    end else begin
      alu_res_mem    <= alu_res;
      st_data_mem    <= rt_data;
      dest_mem       <= dest;
      reg_write_mem  <= reg_write && (dest != '0) && !is_md;
      mem_to_reg_mem <= mem_to_reg;
      mem_write_mem  <= mem_write && !is_md;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// compared against a behavioural model of the ALU and HI/LO arithmetic.
// A second instance with FAST_MUL=1 shares the inputs.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs_data, rt_data, imm, instr;
  logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dst;
  logic [2:0]  alu_op;

  logic        ex_stall_s, rw_s, m2r_s, mw_s;
  logic [31:0] res_s, st_s;
  logic [4:0]  dest_s;
  logic        ex_stall_f, rw_f, m2r_f, mw_f;
  logic [31:0] res_f, st_f;
  logic [4:0]  dest_f;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  ex_stage #(.FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .instr(instr),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .ex_stall(ex_stall_s), .alu_res_mem(res_s),
    .st_data_mem(st_s), .dest_mem(dest_s), .reg_write_mem(rw_s), .mem_to_reg_mem(m2r_s),
    .mem_write_mem(mw_s)
  );

  ex_stage #(.FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst(rst), .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .instr(instr),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .ex_stall(ex_stall_f), .alu_res_mem(res_f),
    .st_data_mem(st_f), .dest_mem(dest_f), .reg_write_mem(rw_f), .mem_to_reg_mem(m2r_f),
    .mem_write_mem(mw_f)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] rt_f,
                       input logic [4:0] rd_f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src, input logic dst,
                       input logic rw, input logic m2r, input logic mw);
    alu_op     = op;
    instr      = {6'd0, 5'd1, rt_f, rd_f, 5'd0, fn};
    rs_data    = a;
    rt_data    = b;
    imm        = im;
    alu_src    = src;
    reg_dst    = dst;
    reg_write  = rw;
    mem_to_reg = m2r;
    mem_write  = mw;
  endtask

  function automatic logic [31:0] model_alu();
    logic [31:0] b;
    b = alu_src ? imm : rt_data;
    case (alu_op)
      3'd1: return rs_data - b;
      3'd2: return rs_data & b;
      3'd3: return rs_data | b;
      3'd4: return (int'(rs_data) < int'(b)) ? 32'd1 : 32'd0;
      3'd5: begin
        case (instr[5:0])
          6'h22: return rs_data - b;
          6'h24: return rs_data & b;
          6'h25: return rs_data | b;
          6'h2A: return (int'(rs_data) < int'(b)) ? 32'd1 : 32'd0;
          6'h10: return hi_m;
          6'h12: return lo_m;
          default: return rs_data + b;
        endcase
      end
      default: return rs_data + b;
    endcase
  endfunction

  task automatic md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t, r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (fn)
      6'h18: begin t = sa * sb; hi_m = t[63:32]; lo_m = t[31:0]; end
      6'h19: begin t = ua * ub; hi_m = t[63:32]; lo_m = t[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi_m = a;
          lo_m = 32'hFFFF_FFFF;
        end else if (fn == 6'h1A) begin
          t = sa / sb; r = sa % sb; hi_m = r[31:0]; lo_m = t[31:0];
        end else begin
          t = ua / ub; r = ua % ub; hi_m = r[31:0]; lo_m = t[31:0];
        end
      end
    endcase
  endtask

  // Runs the instruction currently on the inputs (called just after a posedge)
  task automatic exec(input string tag);
    logic        md;
    logic [31:0] exp_res;
    logic [4:0]  exp_dest;
    logic        exp_rw;
    md = (alu_op == 3'd5) && (instr[5:2] == 4'b0110);
    if (md) begin
      for (int k = 0; k < 33; k++) begin
        @(negedge clk);
        check_eq({tag, " stall"}, ex_stall_s, 1);
        @(posedge clk); #1;
        check_eq({tag, " bubble"}, {24'd0, res_s, dest_s, rw_s, m2r_s, mw_s}, 0);
        check_eq({tag, " bubble_st"}, st_s, 0);
      end
      @(negedge clk);
      check_eq({tag, " done_stall"}, ex_stall_s, 0);
      @(posedge clk); #1;
      check_eq({tag, " retire_ctl"}, {rw_s, mw_s}, 0);
      md_model(instr[5:0], rs_data, rt_data);
    end else begin
      exp_res  = model_alu();
      exp_dest = reg_dst ? instr[15:11] : instr[20:16];
      exp_rw   = reg_write && (exp_dest != 5'd0);
      @(negedge clk);
      check_eq({tag, " stall"}, ex_stall_s, 0);
      check_eq({tag, " stall_f"}, ex_stall_f, 0);
      @(posedge clk); #1;
      check_eq({tag, " res"}, res_s, exp_res);
      check_eq({tag, " ctl"}, {dest_s, rw_s, m2r_s, mw_s}, {exp_dest, exp_rw, mem_to_reg, mem_write});
      check_eq({tag, " st"}, st_s, rt_data);
      check_eq({tag, " res_f"}, res_f, exp_res);
      check_eq({tag, " ctl_f"}, {dest_f, rw_f, m2r_f, mw_f}, {exp_dest, exp_rw, mem_to_reg, mem_write});
      check_eq({tag, " st_f"}, st_f, rt_data);
    end
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
    drive(3'd5, fn, 5'd2, rd, a, b, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exec(tag);
  endtask

  initial begin
    logic [5:0] nonmd_fn [9];
    logic [5:0] md_fn [4];
    logic [31:0] a, b;
    nonmd_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h00, 6'h3F};
    md_fn    = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Reset with an md instruction on the inputs: no stall, outputs cleared
    rst = 1'b1;
    drive(3'd5, 6'h18, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("rst stall", ex_stall_s, 0);
    @(posedge clk); #1;
    check_eq("rst outs", {24'd0, res_s, dest_s, rw_s, m2r_s, mw_s}, 0);
    check_eq("rst st", st_s, 0);
    drive(3'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed: ADD, SLT, zero destination
    rtype(6'h20, 32'd5, 32'd7, 5'd3, "add");
    check_eq("add lit", {res_s, dest_s, rw_s}, {32'd12, 5'd3, 1'b1});
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd4, "slt_neg");
    check_eq("slt_neg lit", res_s, 32'd1);
    rtype(6'h2A, 32'd1, 32'hFFFF_FFFF, 5'd4, "slt_pos");
    check_eq("slt_pos lit", res_s, 32'd0);
    rtype(6'h20, 32'd1, 32'd2, 5'd0, "dest0");
    check_eq("dest0 rw", rw_s, 1'b0);

    // MULT -3*7 then HI/LO reads
    rtype(6'h18, 32'hFFFF_FFFD, 32'd7, 5'd0, "mult");
    rtype(6'h10, 32'd0, 32'd0, 5'd5, "mfhi_mult");
    check_eq("mfhi_mult lit", res_s, 32'hFFFF_FFFF);
    rtype(6'h12, 32'd0, 32'd0, 5'd5, "mflo_mult");
    check_eq("mflo_mult lit", res_s, 32'hFFFF_FFEB);

    // DIV 7/-2 and DIVU 9/0
    rtype(6'h1A, 32'd7, 32'hFFFF_FFFE, 5'd0, "div");
    rtype(6'h12, 32'd0, 32'd0, 5'd6, "mflo_div");
    check_eq("mflo_div lit", res_s, 32'hFFFF_FFFD);
    rtype(6'h10, 32'd0, 32'd0, 5'd6, "mfhi_div");
    check_eq("mfhi_div lit", res_s, 32'd1);
    rtype(6'h1B, 32'd9, 32'd0, 5'd0, "divu0");
    rtype(6'h12, 32'd0, 32'd0, 5'd6, "mflo_divu0");
    check_eq("mflo_divu0 lit", res_s, 32'hFFFF_FFFF);
    rtype(6'h10, 32'd0, 32'd0, 5'd6, "mfhi_divu0");
    check_eq("mfhi_divu0 lit", res_s, 32'd9);

    // Reset in the middle of MULTU 2*3
    drive(3'd5, 6'h19, 5'd2, 5'd0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rmid arrive stall", ex_stall_s, 1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rmid busy stall", ex_stall_s, 1);
    rst = 1'b1;
    drive(3'd0, 6'h00, 5'd9, 5'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rmid rst stall", ex_stall_s, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    exec("rmid add");
    check_eq("rmid add lit", {res_s, dest_s, rw_s}, {32'd42, 5'd9, 1'b1});
    rtype(6'h10, 32'd0, 32'd0, 5'd7, "rmid mfhi");
    check_eq("rmid mfhi lit", res_s, 32'd0);
    rtype(6'h12, 32'd0, 32'd0, 5'd7, "rmid mflo");
    check_eq("rmid mflo lit", res_s, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 3))
          0: b = 32'd0;
          1: b = $urandom_range(1, 20);
          2: b = 32'd0 - $urandom_range(1, 20);
          default: b = $urandom;
        endcase
        drive(3'd5, md_fn[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), a, b, $urandom,
              1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1);
        exec("rnd md");
        rtype(6'h10, 32'd0, 32'd0, 5'd8, "rnd mfhi");
        rtype(6'h12, 32'd0, 32'd0, 5'd8, "rnd mflo");
      end else begin
        drive(3'($urandom_range(0, 7)), nonmd_fn[$urandom_range(0, 8)], 5'($urandom),
              5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
        exec("rnd alu");
      end
    end

    // FAST_MUL instance: MULTU completes without stalling
    rst = 1'b1;
    drive(3'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3'd5, 6'h19, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("fast stall", ex_stall_f, 0);
    @(posedge clk); #1;
    check_eq("fast retire", {rw_f, mw_f}, 0);
    drive(3'd5, 6'h10, 5'd2, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("fast mfhi stall", ex_stall_f, 0);
    @(posedge clk); #1;
    check_eq("fast mfhi", res_f, 32'd1);
    drive(3'd5, 6'h12, 5'd2, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("fast mflo", res_f, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
